axi_rd_arbiter: RTL

//  Two-master, one-slave AXI4 read-channel arbiter in front of the shared AXI RAM.

---
 rtl/axi_rd_arbiter_if.sv | 42 ++++
 rtl/axi_rd_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Read-channel bundle between the two requesting masters, the arbiter and the shared RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              m_arvalid;
  logic [1:0]              m_arready;
  logic [2*ADDR_WIDTH-1:0] m_araddr;
  logic [15:0]             m_arlen;
  logic [5:0]              m_arsize;
  logic [3:0]              m_arburst;
  logic [1:0]              m_rvalid;
  logic [1:0]              m_rready;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic                    m_rlast;

  logic                    s_arvalid;
  logic                    s_arready;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic [7:0]              s_arlen;
  logic [2:0]              s_arsize;
  logic [1:0]              s_arburst;
  logic                    s_rvalid;
  logic                    s_rready;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic                    s_rlast;

  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    input  s_arready, s_rvalid, s_rdata, s_rlast,
    output m_arready, m_rvalid, m_rdata, m_rlast,
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready
  );

  modport master (
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    output s_arready, s_rvalid, s_rdata, s_rlast,
    input  m_arready, m_rvalid, m_rdata, m_rlast,
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter in front of a single RAM read port.
// One burst outstanding at a time; a grant lasts from AR until the RLAST handshake.
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64
) (
  input  logic            clock,
  input  logic            reset,
  axi_rd_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q;
  logic   grant_q;
  logic   last_grant_q;

  logic [ADDR_WIDTH-1:0] araddr_a  [2];
  logic [7:0]            arlen_a   [2];
  logic [2:0]            arsize_a  [2];
  logic [1:0]            arburst_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign araddr_a[gi]  = bus.m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign arlen_a[gi]   = bus.m_arlen[gi*8 +: 8];
    assign arsize_a[gi]  = bus.m_arsize[gi*3 +: 3];
    assign arburst_a[gi] = bus.m_arburst[gi*2 +: 2];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m_arvalid != 2'b00) begin
            // Contention flips away from whoever finished last; otherwise pick the sole requester.
            grant_q <= (bus.m_arvalid == 2'b11) ? ~last_grant_q : bus.m_arvalid[1];
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_arvalid[grant_q] && bus.s_arready) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bus.s_rvalid && bus.m_rready[grant_q] && bus.s_rlast) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset silences them immediately.
  always_comb begin
    bus.m_arready = 2'b00;
    bus.m_rvalid  = 2'b00;
    bus.m_rdata   = {DATA_WIDTH{1'b0}};
    bus.m_rlast   = 1'b0;
    bus.s_arvalid = 1'b0;
    bus.s_araddr  = {ADDR_WIDTH{1'b0}};
    bus.s_arlen   = 8'd0;
    bus.s_arsize  = 3'd0;
    bus.s_arburst = 2'd0;
    bus.s_rready  = 1'b0;
    case (state_q)
      ADDR: begin
        bus.s_arvalid          = bus.m_arvalid[grant_q];
        bus.s_araddr           = araddr_a[grant_q];
        bus.s_arlen            = arlen_a[grant_q];
        bus.s_arsize           = arsize_a[grant_q];
        bus.s_arburst          = arburst_a[grant_q];
        bus.m_arready[grant_q] = bus.s_arready;
      end
      DATA: begin
        bus.m_rvalid[grant_q] = bus.s_rvalid;
        bus.s_rready          = bus.m_rready[grant_q];
        bus.m_rdata           = bus.s_rdata;
        bus.m_rlast           = bus.s_rlast;
      end
      default: ;
    endcase
  end
endmodule
